wb_uart_tx: RTL

Wishbone slave UART transmitter peripheral hanging off the SoC bus decoder alongside SRAM, seven-segment and switch/LED slaves. It is selected at word address 0x3FFF_FC10–0x3FFF_FC13 (byte 0xFFFF_F040–0xFFFF_F04F); the decoder gates `i_wb_stb` with its select. The core writes bytes into an internal FIFO, and the block serialises them as 8N1 frames on `o_tx` at a programmable bit period. Status and interrupt outputs let firmware poll or wait for drain.

---
 rtl/wb_uart_tx.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/wb_uart_tx.sv
// Wishbone slave UART transmitter: a byte FIFO feeding an 8N1 serialiser
// whose bit period is taken from the DIVISOR register at each pop.
module wb_uart_tx #(
  parameter int DEPTH       = 8,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic          w_acc;
  logic          w_wr;
  logic [1:0]    w_reg;
  logic [31:0]   w_rdata;
  logic [31:0]   w_status;
  logic          w_unused;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;

  logic          r_ack;
  logic [31:0]   r_rdata;
  logic          r_ovf;
  logic [15:0]   r_div;

  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_cnt;
  logic [15:0]   w_cnt_next;
  logic [15:0]   r_bitper;
  logic [15:0]   w_bitper_next;
  logic [15:0]   w_div_eff;
  logic [2:0]    r_bitidx;
  logic [2:0]    w_bitidx_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          r_tx;
  logic          w_tx_next;
  logic          w_bit_done;

  assign w_acc      = i_wb_cyc && i_wb_stb;
  assign w_wr       = w_acc && i_wb_we;
  assign w_reg      = i_wb_addr[1:0];
  assign w_unused   = &{1'b0, i_wb_addr[29:2], i_wb_data[31:16], i_wb_sel[3:2]};

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_req = w_wr && (w_reg == 2'd0) && i_wb_sel[0];
  assign w_push     = w_push_req && (!w_full || w_pop);

  assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_bit_done = (r_cnt == r_bitper - 16'd1);

  assign w_status   = {17'b0, 7'(r_count), 4'b0, r_ovf, (r_state != S_IDLE), w_empty, w_full};

  assign o_wb_ack   = r_ack;
  assign o_wb_stall = 1'b0;
  assign o_wb_data  = r_rdata;
  assign o_tx       = r_tx;
  assign o_irq      = w_empty && (r_state == S_IDLE);

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = {16'b0, r_div};
      default: w_rdata = '0;
    endcase
  end

  // Bus side: single-cycle ack, registered read data, DIVISOR and sticky overflow
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_ovf   <= 1'b0;
      r_div   <= 16'(DEFAULT_DIV);
    end else begin
      r_ack <= w_acc;
      if (w_acc) begin
        r_rdata <= i_wb_we ? 32'd0 : w_rdata;
      end
      if (w_push_req && !w_push) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_reg == 2'd1) && i_wb_sel[0] && i_wb_data[3]) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && (w_reg == 2'd2)) begin
        if (i_wb_sel[0]) r_div[7:0]  <= i_wb_data[7:0];
        if (i_wb_sel[1]) r_div[15:8] <= i_wb_data[15:8];
      end
    end
  end

  // Storage is not reset; emptiness is defined purely by the pointers and count
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wb_data[7:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bitper <= 16'd1;
      r_bitidx <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_bitper <= w_bitper_next;
      r_bitidx <= w_bitidx_next;
      r_shift  <= w_shift_next;
      r_tx     <= w_tx_next;
    end
  end

  // r_tx is registered, so each branch sets the line level for the next cycle
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_bitper_next = r_bitper;
    w_bitidx_next = r_bitidx;
    w_shift_next  = r_shift;
    w_tx_next     = 1'b1;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_next  = r_mem[r_rptr];
          w_bitper_next = w_div_eff;
          w_cnt_next    = '0;
          w_tx_next     = 1'b0;
          w_state_next  = S_START;
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_bit_done) begin
          w_cnt_next    = '0;
          w_bitidx_next = '0;
          w_tx_next     = r_shift[0];
          w_state_next  = S_DATA;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
        if (w_bit_done) begin
          w_cnt_next = '0;
          if (r_bitidx == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = S_STOP;
          end else begin
            w_bitidx_next = r_bitidx + 3'd1;
            w_shift_next  = {1'b0, r_shift[7:1]};
            w_tx_next     = r_shift[1];
          end
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_done) begin
          w_cnt_next = '0;
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_next  = r_mem[r_rptr];
            w_bitper_next = w_div_eff;
            w_tx_next     = 1'b0;
            w_state_next  = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule
